// File: rtl/memoria_pkg.sv
// Shared definitions for the memory reader and writer: default widths, the
// memory depth and the output-buffer occupancy encoding.
package memoria_pkg;

  localparam int unsigned DATA_WIDTH    = 10;
  localparam int unsigned ADDRESS_WIDTH = 8;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'(1) << aw;
  endfunction

  localparam int unsigned DEPTH = depth_of(ADDRESS_WIDTH);

  // Occupancy of the reader's 2-entry output buffer
  typedef enum logic [1:0] {
    BUF_VACIO = 2'd0,
    BUF_UNO   = 2'd1,
    BUF_LLENO = 2'd2
  } buf_cnt_t;

endpackage

// File: rtl/lector_memoria_if.sv
// Read-side bus of lector_memoria: memory read port plus the valid/ready
// stream toward the consumer. master = reader, slave = memory + consumer.
interface lector_memoria_if
  import memoria_pkg::*;
#(
  parameter int unsigned data_width    = DATA_WIDTH,
  parameter int unsigned address_width = ADDRESS_WIDTH
);

  logic                     rdmem_enable;
  logic [address_width-1:0] rd_addr;
  logic [data_width-1:0]    memo_data_out;
  logic [data_width-1:0]    data_out;
  logic                     valid;
  logic                     ready;

  modport master (
    output rdmem_enable,
    output rd_addr,
    input  memo_data_out,
    output data_out,
    output valid,
    input  ready
  );

  modport slave (
    input  rdmem_enable,
    input  rd_addr,
    output memo_data_out,
    input  data_out,
    input  valid,
    output ready
  );

endinterface

// File: rtl/lector_buffer_salida.sv
// Two-entry output buffer of the memory reader: head register drives the
// consumer, tail holds a second word so reads can run ahead of a stall.
module lector_buffer_salida
  import memoria_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [data_width-1:0] push_data,
  input  logic                  pop,
  output logic [data_width-1:0] data_out,
  output logic                  valid,
  output buf_cnt_t              buf_cnt
);

  logic [data_width-1:0] cola;

  // Head is data_out itself, so it only moves on a pop or a fill of an empty head
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_cnt  <= BUF_VACIO;
      data_out <= '0;
      cola     <= '0;
      valid    <= 1'b0;
    end else begin
      case (buf_cnt)
        BUF_VACIO: begin
          if (push) begin
            data_out <= push_data;
            valid    <= 1'b1;
            buf_cnt  <= BUF_UNO;
          end
        end
        BUF_UNO: begin
          if (push && pop) begin
            data_out <= push_data;
          end else if (push) begin
            cola    <= push_data;
            buf_cnt <= BUF_LLENO;
          end else if (pop) begin
            valid   <= 1'b0;
            buf_cnt <= BUF_VACIO;
          end
        end
        BUF_LLENO: begin
          if (pop) begin
            data_out <= cola;
            if (push) begin
              cola <= push_data;
            end else begin
              buf_cnt <= BUF_UNO;
            end
          end
        end
        default: begin
          valid   <= 1'b0;
          buf_cnt <= BUF_VACIO;
        end
      endcase
    end
  end

endmodule

// File: rtl/lector_memoria.sv
// Read-side controller for the shared memory: tracks occupancy from the
// writer's strobe, issues reads and streams words out in FIFO order.
// Optional almost_empty flag under `LECTOR_ALMOST_EMPTY_EN.
module lector_memoria
  import memoria_pkg::*;
#(
  parameter int unsigned data_width    = DATA_WIDTH,
  parameter int unsigned address_width = ADDRESS_WIDTH
`ifdef LECTOR_ALMOST_EMPTY_EN
  ,
  parameter int unsigned ALMOST_EMPTY_LVL = 2
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrmem_enable,
  lector_memoria_if.master bus,
  output logic             empty,
  output logic             full,
  output logic             overflow
`ifdef LECTOR_ALMOST_EMPTY_EN
  ,
  output logic             almost_empty
`endif
);

  localparam int unsigned CW = address_width + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth_of(address_width));

  logic [address_width-1:0] rd_ptr;
  logic [CW-1:0]            count;
  logic [CW-1:0]            count_next;
  logic                     inflight;
  buf_cnt_t                 buf_cnt;
  logic                     pop;
  logic                     wr_acc;
  logic                     issue;
  logic [1:0]               ocupado;

  // Read issue: only when the buffer can still hold everything already committed
  always_comb begin
    pop        = bus.valid && bus.ready;
    wr_acc     = wrmem_enable && !full;
    ocupado    = 2'(buf_cnt) + 2'(inflight);
    issue      = !reset && (count != '0) && (3'(ocupado) < (3'd2 + 3'(pop)));
    count_next = count;
    if (wr_acc && !issue) begin
      count_next = count + CW'(1);
    end else if (!wr_acc && issue) begin
      count_next = count - CW'(1);
    end
  end

  assign bus.rdmem_enable = issue;
  assign bus.rd_addr      = rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (issue) begin
        rd_ptr <= rd_ptr + address_width'(1);
      end
      count    <= count_next;
      inflight <= issue;
      empty    <= (count_next == '0);
      full     <= (count_next == DEPTH_C);
      overflow <= overflow | (wrmem_enable && full);
    end
  end

`ifdef LECTOR_ALMOST_EMPTY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      almost_empty <= 1'b1;
    end else begin
      almost_empty <= (count_next <= CW'(ALMOST_EMPTY_LVL));
    end
  end
`endif

  // Data returning from the memory lands in the buffer one cycle after issue
  lector_buffer_salida #(
    .data_width (data_width)
  ) u_buffer (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (bus.memo_data_out),
    .pop       (pop),
    .data_out  (bus.data_out),
    .valid     (bus.valid),
    .buf_cnt   (buf_cnt)
  );

endmodule

// File: tb/tb_lector_memoria.sv
// Self-checking bench for lector_memoria: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_lector_memoria;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wrmem_enable = 1'b0;
  logic       empty, full, overflow;
`ifdef LECTOR_ALMOST_EMPTY_EN
  logic       almost_empty;
`endif
  logic [9:0] din = '0;
  logic       mem_we = 1'b0;
  logic [9:0] mem [256];
  logic [7:0] wr_ptr;

  lector_memoria_if #(.data_width(10), .address_width(8)) bus ();

  lector_memoria dut (
    .clk          (clk),
    .reset        (reset),
    .wrmem_enable (wrmem_enable),
    .bus          (bus),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow)
`ifdef LECTOR_ALMOST_EMPTY_EN
    ,
    .almost_empty (almost_empty)
`endif
  );

  always #5 clk = ~clk;

  // Shared memory plus the writer's address pointer
  always @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (mem_we) begin
      mem[wr_ptr] <= din;
      wr_ptr      <= wr_ptr + 8'd1;
    end
    if (bus.rdmem_enable) bus.memo_data_out <= mem[bus.rd_addr];
  end

  // Reference model: words waiting in memory, word in flight, words buffered
  logic [9:0] mq[$];
  logic [9:0] fq[$];
  logic [9:0] oq[$];
  logic       m_ovf = 1'b0;
  logic [7:0] m_addr = '0;
  logic [7:0] last_issue_addr = '0;
  logic       any_issue = 1'b0;
  logic       wrap_seen = 1'b0;
  logic [9:0] got_q[$];
  int         got_cyc[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic model_pop();
    return (oq.size() > 0) && bus.ready;
  endfunction

  function automatic logic model_issue();
    int occ;
    occ = oq.size() + fq.size() - int'(model_pop());
    return !reset && (mq.size() > 0) && (occ < 2);
  endfunction

  task automatic drive(input logic r, input logic w, input logic [9:0] d, input logic rd);
    @(negedge clk);
    reset        = r;
    wrmem_enable = w;
    din          = d;
    bus.ready    = rd;
    mem_we       = w && !r && (mq.size() < 256);
    #1;
  endtask

  task automatic check_model();
    logic iss;
    iss = model_issue();
    chk("rdmem_enable", 32'(bus.rdmem_enable), 32'(iss));
    if (iss) chk("rd_addr", 32'(bus.rd_addr), 32'(m_addr));
    chk("valid", 32'(bus.valid), 32'(oq.size() > 0));
    if (oq.size() > 0) chk("data_out", 32'(bus.data_out), 32'(oq[0]));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == 256));
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef LECTOR_ALMOST_EMPTY_EN
    chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= 2));
`endif
  endtask

  task automatic advance();
    logic pop, iss, full_pre;
    pop      = model_pop();
    iss      = model_issue();
    full_pre = (mq.size() == 256);
    if (pop && !reset) begin
      got_q.push_back(bus.data_out);
      got_cyc.push_back(cyc);
    end
    if (iss) begin
      if (any_issue && last_issue_addr == 8'd255 && bus.rd_addr == 8'd0) wrap_seen = 1'b1;
      last_issue_addr = bus.rd_addr;
      any_issue       = 1'b1;
    end
    @(posedge clk);
    cyc++;
    if (reset) begin
      mq.delete();
      fq.delete();
      oq.delete();
      m_ovf  = 1'b0;
      m_addr = '0;
    end else begin
      if (wrmem_enable && full_pre) m_ovf = 1'b1;
      if (pop) void'(oq.pop_front());
      if (fq.size() > 0) oq.push_back(fq.pop_front());
      if (iss) begin
        fq.push_back(mq.pop_front());
        m_addr++;
      end
      if (wrmem_enable && !full_pre) mq.push_back(din);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [9:0] d, input logic rd);
    drive(r, w, d, rd);
    check_model();
    advance();
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, 1'b0);
    advance();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    got_q.delete();
    got_cyc.delete();
  endtask

  typedef struct {
    logic       rst;
    logic       wr;
    logic [9:0] d;
    logic       rdy;
    logic       e_rd;
    logic [7:0] e_addr;
    logic       e_valid;
    logic [9:0] e_data;
    logic       e_empty;
    logic       e_full;
  } vec_t;

  vec_t       tbl[5];
  logic [9:0] wl[$];
  logic [9:0] held;

  initial begin
    tbl[0] = '{1'b0, 1'b1, 10'b0111000101, 1'b1, 1'b0, 8'd0, 1'b0, 10'd0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 10'd0,          1'b1, 1'b1, 8'd0, 1'b0, 10'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 10'd0,          1'b1, 1'b0, 8'd0, 1'b0, 10'd0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 10'd0,          1'b1, 1'b0, 8'd0, 1'b1, 10'b0111000101, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 10'd0,          1'b1, 1'b0, 8'd0, 1'b0, 10'd0, 1'b1, 1'b0};
    bus.ready = 1'b0;

    // Reset state
    do_reset();
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_rdmem", 32'(bus.rdmem_enable), 32'd0);
    check_model();
    advance();

    // Single write: write-to-valid latency
    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].rst, tbl[i].wr, tbl[i].d, tbl[i].rdy);
      chk("tbl_rdmem", 32'(bus.rdmem_enable), 32'(tbl[i].e_rd));
      if (tbl[i].e_rd) chk("tbl_rd_addr", 32'(bus.rd_addr), 32'(tbl[i].e_addr));
      chk("tbl_valid", 32'(bus.valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk("tbl_data_out", 32'(bus.data_out), 32'(tbl[i].e_data));
      chk("tbl_empty", 32'(empty), 32'(tbl[i].e_empty));
      chk("tbl_full", 32'(full), 32'(tbl[i].e_full));
      check_model();
      advance();
    end

    // Burst of 9 writes with ready held: in order, one per cycle
    do_reset();
    wl.delete();
    wl.push_back(10'b1111111111);
    wl.push_back(10'b1100001011);
    for (int i = 0; i < 7; i++) wl.push_back(10'($urandom));
    foreach (wl[i]) step(1'b0, 1'b1, wl[i], 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);
    chk("burst_count", 32'(got_q.size()), 32'd9);
    foreach (wl[i]) if (i < got_q.size()) chk("burst_order", 32'(got_q[i]), 32'(wl[i]));
    if (got_cyc.size() == 9) chk("burst_no_gaps", 32'(got_cyc[8] - got_cyc[0]), 32'd8);

    // Stall: 5 writes with ready low, 2 buffered, then release
    do_reset();
    wl.delete();
    for (int i = 0; i < 5; i++) wl.push_back(10'($urandom));
    foreach (wl[i]) step(1'b0, 1'b1, wl[i], 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("stall_valid", 32'(bus.valid), 32'd1);
    chk("stall_rdmem", 32'(bus.rdmem_enable), 32'd0);
    chk("stall_empty", 32'(empty), 32'd0);
    chk("stall_head", 32'(bus.data_out), 32'(wl[0]));
    held = bus.data_out;
    advance();
    step(1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("stall_stable", 32'(bus.data_out), 32'(held));
    advance();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1);
    chk("stall_count", 32'(got_q.size()), 32'd5);
    foreach (wl[i]) if (i < got_q.size()) chk("stall_order", 32'(got_q[i]), 32'(wl[i]));

    // Fill to full, overflow, drain across the address wrap
    do_reset();
    wl.delete();
    any_issue = 1'b0;
    wrap_seen = 1'b0;
    for (int i = 0; i < 258; i++) begin
      wl.push_back(10'($urandom));
      step(1'b0, 1'b1, wl[i], 1'b0);
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_no_ovf", 32'(overflow), 32'd0);
    advance();
    step(1'b0, 1'b1, 10'h155, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_still_full", 32'(full), 32'd1);
    advance();
    for (int i = 0; i < 270; i++) step(1'b0, 1'b0, '0, 1'b1);
    chk("drain_count", 32'(got_q.size()), 32'd258);
    chk("drain_wrap", 32'(wrap_seen), 32'd1);
    if (got_q.size() > 256) chk("after_wrap_word", 32'(got_q[256]), 32'(wl[256]));
    foreach (wl[i]) if (i < got_q.size()) chk("drain_order", 32'(got_q[i]), 32'(wl[i]));
    drive(1'b0, 1'b0, '0, 1'b1);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("drain_empty", 32'(empty), 32'd1);
    advance();

    // Reset the cycle after an issue: returning data is discarded
    do_reset();
    step(1'b0, 1'b1, 10'h2AA, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("pre_rst_issue", 32'(bus.rdmem_enable), 32'd1);
    advance();
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      chk("post_rst_valid", 32'(bus.valid), 32'd0);
      chk("post_rst_empty", 32'(empty), 32'd1);
      check_model();
      advance();
    end

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(1'b0 || ($urandom_range(0, 299) == 0),
           1'($urandom_range(0, 1)),
           10'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
